// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with single-word refill over the iREN/iwait port.
// Optional hit/miss counters are built in when ICACHE_STATS_EN is defined.
module icache #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t             state, next_state;
  logic [31:2]        miss_word;
  logic [SETS-1:0]    valid;
  logic [TAG_W-1:0]   tags [SETS];
  logic [31:0]        data [SETS];

  logic [IDX_W-1:0]   req_idx, fill_idx;
  logic [TAG_W-1:0]   req_tag, fill_tag;
  logic               lookup_hit;
  logic               miss;
  logic               fill;
  logic               unused_offset;

  assign req_idx       = imemaddr[IDX_W+1:2];
  assign req_tag       = imemaddr[31:IDX_W+2];
  assign fill_idx      = miss_word[IDX_W+1:2];
  assign fill_tag      = miss_word[31:IDX_W+2];
  assign unused_offset = ^imemaddr[1:0];

  assign lookup_hit = imemREN & valid[req_idx] & (tags[req_idx] == req_tag);
  assign imemload   = data[req_idx];
  // iaddr comes only from the latched miss address, never from imemaddr.
  assign iaddr      = {miss_word, 2'b00};

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    next_state = state;
    ihit       = 1'b0;
    iREN       = 1'b0;
    miss       = 1'b0;
    fill       = 1'b0;
    unique case (state)
      IDLE: begin
        ihit = lookup_hit;
        if (imemREN && !lookup_hit) begin
          miss       = 1'b1;
          next_state = FETCH;
        end
      end
      FETCH: begin
        iREN = 1'b1;
        if (!iwait) begin
          fill       = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (RST) begin
      state     <= IDLE;
      valid     <= '0;
      miss_word <= '0;
    end else begin
      state <= next_state;
      if (miss)
        miss_word <= imemaddr[31:2];
      if (fill)
        valid[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: tag/data arrays have no reset; valid alone qualifies them, keeping them plain RAM.
    if (!RST && fill) begin
      tags[fill_idx] <= fill_tag;
      data[fill_idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (ihit)
        hit_cnt <= hit_cnt + 32'd1;
      if (miss)
        miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: per-cycle vector table plus reset-mid-refill and stats sequences.
module tb_icache;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  icache #(.SETS(16)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ren;
    logic [31:0] addr;
    logic        iw;
    logic [31:0] ld;
    logic        e_hit;
    logic [31:0] e_load;
    logic        e_iren;
    logic [31:0] e_iaddr;
  } vec_t;

  vec_t vecs [64];
  int   nvec   = 0;
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic add(input logic ren, input logic [31:0] addr, input logic iw,
                     input logic [31:0] ld, input logic e_hit, input logic [31:0] e_load,
                     input logic e_iren, input logic [31:0] e_iaddr);
    vecs[nvec] = '{ren, addr, iw, ld, e_hit, e_load, e_iren, e_iaddr};
    nvec++;
  endtask

  task automatic drive(input logic rst, input logic ren, input logic [31:0] addr,
                       input logic iw, input logic [31:0] ld);
    RST = rst; imemREN = ren; imemaddr = addr; iwait = iw; iload = ld;
    #2;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h0);
    tick();
    RST = 1'b0;
  endtask

  initial begin
    //  ren addr          iw ld            hit load          iren iaddr
    add(0, 32'h0000_0000, 1, 32'h0,        0, 32'h0,         0, 32'h0);    // reset state
    add(1, 32'h0000_0040, 1, 32'h0,        0, 32'h0,         0, 32'h0);    // cold miss
    add(1, 32'h0000_0040, 1, 32'h0,        0, 32'h0,         1, 32'h40);
    add(1, 32'h0000_0040, 1, 32'h0,        0, 32'h0,         1, 32'h40);
    add(1, 32'h0000_0040, 0, 32'h2008_0001,0, 32'h0,         1, 32'h40);
    add(1, 32'h0000_0040, 1, 32'h0,        1, 32'h2008_0001, 0, 32'h0);    // hit after fill
    add(1, 32'h0000_0000, 1, 32'h0,        0, 32'h0,         0, 32'h0);    // fill 0x0, N=0
    add(1, 32'h0000_0000, 0, 32'h0000_00A0,0, 32'h0,         1, 32'h0);
    add(1, 32'h0000_0004, 1, 32'h0,        0, 32'h0,         0, 32'h0);    // fill 0x4
    add(1, 32'h0000_0004, 0, 32'h0000_00A4,0, 32'h0,         1, 32'h4);
    add(1, 32'h0000_0008, 1, 32'h0,        0, 32'h0,         0, 32'h0);    // fill 0x8
    add(1, 32'h0000_0008, 0, 32'h0000_00A8,0, 32'h0,         1, 32'h8);
    add(1, 32'h0000_0000, 1, 32'h0,        1, 32'h0000_00A0, 0, 32'h0);    // warm hits
    add(1, 32'h0000_0004, 1, 32'h0,        1, 32'h0000_00A4, 0, 32'h0);
    add(1, 32'h0000_0008, 1, 32'h0,        1, 32'h0000_00A8, 0, 32'h0);
    add(1, 32'h0000_0003, 1, 32'h0,        1, 32'h0000_00A0, 0, 32'h0);    // offset ignored
    add(1, 32'h0000_0044, 1, 32'h0,        0, 32'h0,         0, 32'h0);    // conflict on idx 1
    add(1, 32'h0000_0044, 0, 32'h0000_00B4,0, 32'h0,         1, 32'h44);
    add(1, 32'h0000_0044, 1, 32'h0,        1, 32'h0000_00B4, 0, 32'h0);
    add(1, 32'h0000_0004, 1, 32'h0,        0, 32'h0,         0, 32'h0);    // 0x4 evicted
    add(1, 32'h0000_0004, 1, 32'h0,        0, 32'h0,         1, 32'h4);
    add(1, 32'h0000_0004, 0, 32'h0000_00A4,0, 32'h0,         1, 32'h4);
    add(1, 32'h0000_0004, 1, 32'h0,        1, 32'h0000_00A4, 0, 32'h0);
    add(0, 32'h0000_0080, 1, 32'h0,        0, 32'h0,         0, 32'h0);    // no request
    add(0, 32'h0000_0080, 1, 32'h0,        0, 32'h0,         0, 32'h0);
    add(0, 32'h0000_0004, 1, 32'h0,        0, 32'h0,         0, 32'h0);    // valid line, REN=0
    add(1, 32'h0000_0100, 1, 32'h0,        0, 32'h0,         0, 32'h0);    // redirect
    add(1, 32'h0000_0200, 1, 32'h0,        0, 32'h0,         1, 32'h100);
    add(0, 32'h0000_0200, 1, 32'h0,        0, 32'h0,         1, 32'h100);
    add(1, 32'h0000_0200, 0, 32'h0000_00C0,0, 32'h0,         1, 32'h100);
    add(1, 32'h0000_0200, 1, 32'h0,        0, 32'h0,         0, 32'h0);    // misses again
    add(1, 32'h0000_0200, 0, 32'h0000_00D0,0, 32'h0,         1, 32'h200);
    add(1, 32'h0000_0200, 1, 32'h0,        1, 32'h0000_00D0, 0, 32'h0);
    add(1, 32'h0000_0100, 1, 32'h0,        0, 32'h0,         0, 32'h0);
    add(1, 32'h0000_0100, 0, 32'h0000_00C0,0, 32'h0,         1, 32'h100);
    add(1, 32'h0000_0100, 1, 32'h0,        1, 32'h0000_00C0, 0, 32'h0);

    do_reset();
    for (int i = 0; i < nvec; i++) begin
      drive(1'b0, vecs[i].ren, vecs[i].addr, vecs[i].iw, vecs[i].ld);
      check($sformatf("row%0d ihit", i), {31'b0, ihit}, {31'b0, vecs[i].e_hit});
      if (vecs[i].e_hit)
        check($sformatf("row%0d imemload", i), imemload, vecs[i].e_load);
      check($sformatf("row%0d iREN", i), {31'b0, iREN}, {31'b0, vecs[i].e_iren});
      if (vecs[i].e_iren || i == 0)
        check($sformatf("row%0d iaddr", i), iaddr, vecs[i].e_iaddr);
      tick();
    end

    // Reset in the 2nd FETCH cycle with iwait=0: the fill must be dropped.
    drive(1'b0, 1'b1, 32'h0000_0300, 1'b1, 32'h0);
    check("rst_mid miss", {31'b0, ihit}, 32'h0);
    tick();
    drive(1'b0, 1'b1, 32'h0000_0300, 1'b1, 32'h0);
    check("rst_mid fetch1 iREN", {31'b0, iREN}, 32'h1);
    check("rst_mid fetch1 iaddr", iaddr, 32'h300);
    tick();
    drive(1'b1, 1'b1, 32'h0000_0300, 1'b0, 32'h0000_00EE);
    check("rst_mid fetch2 iREN", {31'b0, iREN}, 32'h1);
    tick();
    drive(1'b0, 1'b0, 32'h0000_0300, 1'b1, 32'h0);
    check("rst_mid after iREN", {31'b0, iREN}, 32'h0);
    check("rst_mid after iaddr", iaddr, 32'h0);
    tick();
    drive(1'b0, 1'b1, 32'h0000_0300, 1'b1, 32'h0);
    check("rst_mid line not written", {31'b0, ihit}, 32'h0);
    tick();
    drive(1'b0, 1'b1, 32'h0000_0300, 1'b0, 32'h0000_00EF);
    check("rst_mid refetch iaddr", iaddr, 32'h300);
    tick();
    drive(1'b0, 1'b1, 32'h0000_0300, 1'b1, 32'h0);
    check("rst_mid refill hit", {31'b0, ihit}, 32'h1);
    check("rst_mid refill data", imemload, 32'h0000_00EF);
    tick();

`ifdef ICACHE_STATS_EN
    do_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    check("stats reset hit_cnt", hit_cnt, 32'h0);
    check("stats reset miss_cnt", miss_cnt, 32'h0);
    for (int m = 0; m < 3; m++) begin
      logic [31:0] a;
      a = 32'h10 + 32'(m) * 32'h4;
      drive(1'b0, 1'b1, a, 1'b1, 32'h0);          tick();  // miss
      drive(1'b0, 1'b1, a, 1'b0, 32'h5000 + a);   tick();  // fill, N=0
      drive(1'b0, 1'b1, a, 1'b1, 32'h0);          tick();  // hit
      if (m != 1) begin
        drive(1'b0, 1'b1, a, 1'b1, 32'h0);        tick();  // second hit
      end
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    check("stats miss_cnt", miss_cnt, 32'd3);
    check("stats hit_cnt", hit_cnt, 32'd5);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    check("stats cleared hit_cnt", hit_cnt, 32'h0);
    check("stats cleared miss_cnt", miss_cnt, 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
